cfg_dump_streamer: RTL
======================

CFG_DUMP_STREAMER -- requirements
Module: cfg_dump_streamer

Interface
REQ-001 SHALL have parameter CVA6Cfg, type config_pkg::cva6_cfg_t, default config_pkg::cva6_cfg_empty; it is the derived configuration that the block streams out.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start_i, input, 1 bit: request a dump.
REQ-005 SHALL have port abort_i, input, 1 bit: cancel any dump in progress.
REQ-006 SHALL have port data_o, output, 32 bits: the current word.
REQ-007 SHALL have port valid_o, output, 1 bit: data_o is valid.
REQ-008 SHALL have port ready_i, input, 1 bit: the consumer accepts data_o.
REQ-009 SHALL have port last_o, output, 1 bit: the current word is the checksum trailer.
REQ-010 SHALL have port busy_o, output, 1 bit: a dump is in progress.
REQ-011 SHALL have port done_o, output, 1 bit: one-cycle pulse when a dump completes.

Function
REQ-012 A handshake is defined as valid_o && ready_i in the same cycle.
REQ-013 Word table, each field truncated to the LSBs of its slice:
- W0 = 0xC7A6_0001 (magic and version).
- W1 = {XLEN, VLEN, PLEN, GPLEN}, 8 bits each.
- W2 = ISA bitmap. bits 0-13: RVA, RVB, RVC, RVD, RVF, RVH, RVS, RVU, RVV, RVZCB, RVZCMP, RVZiCond, RVZicntr, RVZihpm. bits 14-23: XF16, XF16ALT, XF8, XF8ALT, XFVec, CvxifEn, FpPresent, MmuPresent, DebugEn, SuperscalarEn. bits 24-31 = 0.
- W3 = {NrCommitPorts, NrIssuePorts, NrWbPorts, NR_SB_ENTRIES}, 8 bits each.
- W4 = {ICACHE_SET_ASSOC, DCACHE_SET_ASSOC, ICACHE_INDEX_WIDTH, DCACHE_INDEX_WIDTH}, 8 bits each.
- W5 = {ICACHE_LINE_WIDTH[15:0], DCACHE_LINE_WIDTH[15:0]}.
- W6 = {InstrTlbEntries, DataTlbEntries, NrPMPEntries, FLen}, 8 bits each.
- W7 = DmBaseAddress[31:0].
- W8 = checksum, the XOR of W0..W7.
REQ-014 FSM states SHALL be IDLE, SEND, DONE.
REQ-015 IDLE: start_i=1 and abort_i=0 SHALL go to SEND with index=0 and accumulator=0; valid_o SHALL rise the next cycle (latency 1).
REQ-016 SEND: valid_o=1 and data_o=W[index]; data_o and last_o SHALL remain stable while ready_i=0.
REQ-017 SEND, handshake with index<8: accumulator ^= data_o and index++; the next word SHALL be presented in the following cycle with no bubble.
REQ-018 Word 8 SHALL be driven from the registered accumulator, not from a constant.
REQ-019 last_o SHALL be 1 only when index==8 and valid_o=1.
REQ-020 SEND, handshake at index==8 SHALL go to DONE; DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-021 busy_o SHALL be 1 in SEND and DONE.
REQ-022 start_i SHALL be ignored in SEND and DONE; a start in the DONE cycle is dropped.
REQ-023 abort_i in SEND or DONE SHALL force IDLE on the next edge, with valid_o=0, done_o=0, index=0 and accumulator=0; no done pulse is produced.
REQ-024 start_i and abort_i together in IDLE: abort wins and the block stays in IDLE.
REQ-025 abort_i and a handshake in the same cycle: the handshake counts for the consumer, and abort still forces IDLE.
REQ-026 index SHALL be 4 bits and SHALL never exceed 8; no wrap-around is reachable.

Reset
REQ-027 While rst_ni=0, the block SHALL asynchronously enter IDLE with index=0 and accumulator=0.
REQ-028 Output reset values: valid_o=0, last_o=0, busy_o=0, done_o=0, data_o=0.
REQ-029 Reset asserted mid-dump SHALL discard the dump; after release, a new start_i is required.

Structure
REQ-030 cfg_dump_pkg SHALL hold:
- NumWords=9 and MagicWord;
- ISA bit-position localparams;
- the state enum type;
- function cfg_word(cfg, idx), returning W0..W7.
REQ-031 The block SHALL be a single module with no sub-module; the word mux is the pure-combinational cfg_dump_pkg::cfg_word.
REQ-032 The state register, index register and accumulator register SHALL be the only sequential elements.

Verification
REQ-033 cv64a6 config, start pulse, ready_i=1 constantly -> W1=0x40403829; 9 words on consecutive cycles; last_o only on word 8; done_o one cycle later; W8 equals the bench XOR model.
REQ-034 ready_i randomly low 50% of cycles -> data_o and last_o stable while stalled; word sequence and checksum identical to REQ-033.
REQ-035 abort_i at index=4 -> valid_o=0 and busy_o=0 on the next cycle, no done_o; a following start yields W0=0xC7A60001 first.
REQ-036 start_i held high throughout a dump -> exactly one dump of 9 words; the next dump starts only after DONE, from IDLE.
REQ-037 rst_ni low at index=6 -> outputs go to 0 immediately; after release there is no activity until start_i.
REQ-038 start_i and abort_i together in IDLE -> busy_o remains 0.

Source files
------------

// File: rtl/cfg_dump_pkg.sv
// Word layout, ISA bitmap positions and FSM encoding for the config dump.
// cfg_word() is the pure word mux for the fixed part of the dump (W0..W7).
package cfg_dump_pkg;

    localparam int unsigned NumWords  = 9;
    localparam logic [31:0] MagicWord = 32'hC7A6_0001;
    localparam logic [3:0]  LastIdx   = 4'(NumWords - 1);

    localparam int unsigned IsaRvaBit           = 0;
    localparam int unsigned IsaRvbBit           = 1;
    localparam int unsigned IsaRvcBit           = 2;
    localparam int unsigned IsaRvdBit           = 3;
    localparam int unsigned IsaRvfBit           = 4;
    localparam int unsigned IsaRvhBit           = 5;
    localparam int unsigned IsaRvsBit           = 6;
    localparam int unsigned IsaRvuBit           = 7;
    localparam int unsigned IsaRvvBit           = 8;
    localparam int unsigned IsaRvzcbBit         = 9;
    localparam int unsigned IsaRvzcmpBit        = 10;
    localparam int unsigned IsaRvzicondBit      = 11;
    localparam int unsigned IsaRvzicntrBit      = 12;
    localparam int unsigned IsaRvzihpmBit       = 13;
    localparam int unsigned IsaXf16Bit          = 14;
    localparam int unsigned IsaXf16altBit       = 15;
    localparam int unsigned IsaXf8Bit           = 16;
    localparam int unsigned IsaXf8altBit        = 17;
    localparam int unsigned IsaXfvecBit         = 18;
    localparam int unsigned IsaCvxifEnBit       = 19;
    localparam int unsigned IsaFpPresentBit     = 20;
    localparam int unsigned IsaMmuPresentBit    = 21;
    localparam int unsigned IsaDebugEnBit       = 22;
    localparam int unsigned IsaSuperscalarEnBit = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] cfg_word(input config_pkg::cva6_cfg_t cfg,
                                             input logic [3:0] idx);
        logic [31:0] isa;
        logic [31:0] word;
        isa = '0;
        isa[IsaRvaBit]           = cfg.RVA;
        isa[IsaRvbBit]           = cfg.RVB;
        isa[IsaRvcBit]           = cfg.RVC;
        isa[IsaRvdBit]           = cfg.RVD;
        isa[IsaRvfBit]           = cfg.RVF;
        isa[IsaRvhBit]           = cfg.RVH;
        isa[IsaRvsBit]           = cfg.RVS;
        isa[IsaRvuBit]           = cfg.RVU;
        isa[IsaRvvBit]           = cfg.RVV;
        isa[IsaRvzcbBit]         = cfg.RVZCB;
        isa[IsaRvzcmpBit]        = cfg.RVZCMP;
        isa[IsaRvzicondBit]      = cfg.RVZiCond;
        isa[IsaRvzicntrBit]      = cfg.RVZicntr;
        isa[IsaRvzihpmBit]       = cfg.RVZihpm;
        isa[IsaXf16Bit]          = cfg.XF16;
        isa[IsaXf16altBit]       = cfg.XF16ALT;
        isa[IsaXf8Bit]           = cfg.XF8;
        isa[IsaXf8altBit]        = cfg.XF8ALT;
        isa[IsaXfvecBit]         = cfg.XFVec;
        isa[IsaCvxifEnBit]       = cfg.CvxifEn;
        isa[IsaFpPresentBit]     = cfg.FpPresent;
        isa[IsaMmuPresentBit]    = cfg.MmuPresent;
        isa[IsaDebugEnBit]       = cfg.DebugEn;
        isa[IsaSuperscalarEnBit] = cfg.SuperscalarEn;

        case (idx)
            4'd0: word = MagicWord;
            4'd1: word = {cfg.XLEN[7:0], cfg.VLEN[7:0], cfg.PLEN[7:0], cfg.GPLEN[7:0]};
            4'd2: word = isa;
            4'd3: word = {cfg.NrCommitPorts[7:0], cfg.NrIssuePorts[7:0],
                          cfg.NrWbPorts[7:0], cfg.NR_SB_ENTRIES[7:0]};
            4'd4: word = {cfg.ICACHE_SET_ASSOC[7:0], cfg.DCACHE_SET_ASSOC[7:0],
                          cfg.ICACHE_INDEX_WIDTH[7:0], cfg.DCACHE_INDEX_WIDTH[7:0]};
            4'd5: word = {cfg.ICACHE_LINE_WIDTH[15:0], cfg.DCACHE_LINE_WIDTH[15:0]};
            4'd6: word = {cfg.InstrTlbEntries[7:0], cfg.DataTlbEntries[7:0],
                          cfg.NrPMPEntries[7:0], cfg.FLen[7:0]};
            4'd7: word = cfg.DmBaseAddress[31:0];
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/config_pkg.sv
// Minimal derived-configuration type consumed by the config dump streamer.
// It carries only the fields that are serialised into the dump.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned VLEN;
        int unsigned PLEN;
        int unsigned GPLEN;
        logic        RVA;
        logic        RVB;
        logic        RVC;
        logic        RVD;
        logic        RVF;
        logic        RVH;
        logic        RVS;
        logic        RVU;
        logic        RVV;
        logic        RVZCB;
        logic        RVZCMP;
        logic        RVZiCond;
        logic        RVZicntr;
        logic        RVZihpm;
        logic        XF16;
        logic        XF16ALT;
        logic        XF8;
        logic        XF8ALT;
        logic        XFVec;
        logic        CvxifEn;
        logic        FpPresent;
        logic        MmuPresent;
        logic        DebugEn;
        logic        SuperscalarEn;
        int unsigned NrCommitPorts;
        int unsigned NrIssuePorts;
        int unsigned NrWbPorts;
        int unsigned NR_SB_ENTRIES;
        int unsigned ICACHE_SET_ASSOC;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned DCACHE_INDEX_WIDTH;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned DCACHE_LINE_WIDTH;
        int unsigned InstrTlbEntries;
        int unsigned DataTlbEntries;
        int unsigned NrPMPEntries;
        int unsigned FLen;
        logic [63:0] DmBaseAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cfg_dump_streamer.sv
// Streams the derived core configuration as 8 words plus an XOR checksum
// trailer over a valid/ready interface, one dump per start request.
module cfg_dump_streamer
    import cfg_dump_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic        busy_o,
    output logic        done_o
);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] acc_q, acc_d;
    logic        hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    assign hs = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = SEND;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            SEND: begin
                if (hs) begin
                    if (idx_q == LastIdx) begin
                        state_d = DONE;
                        idx_d   = '0;
                        acc_d   = '0;
                    end else begin
                        acc_d = acc_q ^ data_o;
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a handshake in this cycle.
        if (abort_i) begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
        end
    end

    always_comb begin
        valid_o = 1'b0;
        last_o  = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        data_o  = '0;
        case (state_q)
            SEND: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                last_o  = (idx_q == LastIdx);
                // The trailer comes from the running XOR, never a precomputed constant.
                data_o  = (idx_q == LastIdx) ? acc_q : cfg_word(CVA6Cfg, idx_q);
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
